// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter peripheral: FSM states, register selects, status bit map.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

    // Transmit FSM states; S_PARITY is only entered when parity is built in
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } uart_state_e;

    // Bus register select
    localparam logic REG_DATA = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    // Status word bit positions
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_PAR     = 12;
    localparam int ST_DIV_LSB = 16;

    // Field widths inside the status word
    localparam int CNT_W = 8;
    localparam int DIV_W = 16;

    // Smallest usable baud divisor (a 1-cycle bit period would break the reload scheme)
    localparam logic [DIV_W-1:0] DIV_MIN = 16'd2;

    // Clamp a requested divisor to the supported minimum
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with first-word fall-through read data and occupancy count.
// Latency: a push is visible at o_rdata/o_empty one cycle after the capturing edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle, which frees the slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: bus bytes are queued in a FIFO and shifted out 8N1 (8E1 with UART_TX_PARITY_EN).
// Latency: DATA write at edge k into an empty idle FIFO is popped at k+1, start bit appears on tx after k+2.
// Backpressure: none on the bus; writes to a full FIFO are dropped and latch a sticky overflow flag.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy,
    output logic        irq
);

    localparam int               CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_RST_V  = DIV_W'(DIV_RESET);
`ifdef UART_TX_PARITY_EN
    localparam logic             PAR_BUILT  = 1'b1;
`else
    localparam logic             PAR_BUILT  = 1'b0;
`endif

    // Bus-side state
    logic [DIV_W-1:0] r_div_reg;
    logic             r_ovf;

    // Transmit datapath state
    uart_state_e      r_state;
    logic [DIV_W-1:0] r_baud_cnt;
    logic [DIV_W-1:0] r_div_lat;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_stop_done;
    logic             r_irq;

    // Combinational signals
    uart_state_e      w_state_nxt;
    logic             w_tick;
    logic             w_load;
    logic             w_fifo_pop;
    logic             w_last_done;
    logic             w_tx_nxt;
    logic             w_data_wr;
    logic             w_ctrl_wr;
    logic [7:0]       w_fifo_rdata;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CW-1:0]    w_fifo_count;
    logic             w_busy;
    logic             w_unused_wdata;

    assign w_data_wr      = we & (reg_sel == REG_DATA);
    assign w_ctrl_wr      = we & (reg_sel == REG_CTRL);
    assign w_tick         = (r_baud_cnt == '0);
    assign w_busy         = (r_state != S_IDLE) | ~w_fifo_empty;
    assign w_unused_wdata = ^wdata[30:16];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_data_wr),
        .i_wdata (wdata[7:0]),
        .i_pop   (w_fifo_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Divisor register and sticky overflow flag written from the bus
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_reg <= DIV_RST_V;
            r_ovf     <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_div_reg <= clamp_div(wdata[15:0]);
            end
            // Overflow only when the write really is dropped: a same-cycle pop makes room
            if (w_data_wr && w_fifo_full && !w_fifo_pop) begin
                r_ovf <= 1'b1;
            end else if (w_ctrl_wr && wdata[31]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Next-state, FIFO pop and line value for the current state
    always_comb begin
        w_state_nxt = r_state;
        w_fifo_pop  = 1'b0;
        w_load      = 1'b0;
        w_last_done = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_fifo_pop  = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shift[r_bit_idx];
                if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                w_tx_nxt = ^r_shift;
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_tick) begin
                    // Chain straight into the next frame when more bytes are queued
                    if (!w_fifo_empty) begin
                        w_fifo_pop  = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_last_done = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame datapath: byte capture, per-frame divisor latch, bit timer and bit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_div_lat  <= DIV_RST_V;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
        end else if (w_load) begin
            r_shift    <= w_fifo_rdata;
            r_div_lat  <= r_div_reg;
            r_baud_cnt <= r_div_reg - DIV_W'(1);
            r_bit_idx  <= '0;
        end else if (r_state != S_IDLE) begin
            if (w_tick) begin
                r_baud_cnt <= r_div_lat - DIV_W'(1);
                if (r_state == S_DATA) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt - DIV_W'(1);
            end
        end
    end

    // Line register lags the state by one cycle; irq is delayed to match so it fires as the stop bit leaves the line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx        <= 1'b1;
            r_stop_done <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_tx        <= w_tx_nxt;
            r_stop_done <= w_last_done;
            r_irq       <= r_stop_done;
        end
    end

    // Status word assembled from registered state
    always_comb begin
        rdata                          = '0;
        rdata[ST_EMPTY]                = w_fifo_empty;
        rdata[ST_FULL]                 = w_fifo_full;
        rdata[ST_BUSY]                 = w_busy;
        rdata[ST_OVF]                  = r_ovf;
        rdata[ST_CNT_LSB +: CNT_W]     = CNT_W'(w_fifo_count);
        rdata[ST_PAR]                  = PAR_BUILT;
        rdata[ST_DIV_LSB +: DIV_W]     = r_div_reg;
    end

    assign tx   = r_tx;
    assign busy = w_busy;
    assign irq  = r_irq;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: table-driven CTRL vectors, scripted corner cases and random frame streams.
// Latency: expected line waveform starts two edges after the first DATA write.
// Backpressure: exercises FIFO full, overflow and push-while-popping.
module tb_uart_tx_periph;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam logic [15:0] ST_IDLE_LO = PAR_EN ? 16'h1001 : 16'h0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic        reg_sel = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;
    logic        irq;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        sel;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    uart_tx_periph #(
        .FIFO_DEPTH (16),
        .DIV_RESET  (868)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .reg_sel (reg_sel),
        .wdata   (wdata),
        .rdata   (rdata),
        .tx      (tx),
        .busy    (busy),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic sel, input logic [31:0] d);
        we = 1'b1;
        reg_sel = sel;
        wdata = d;
        step(1);
        we = 1'b0;
        wdata = '0;
    endtask

    // Writes bytes on consecutive cycles (plus an optional CTRL write at cycle ctrl_cyc) and
    // compares tx, irq and the FIFO count against a waveform built from the 8N1/8E1 framing rules.
    task automatic run_stream(input string nm, input logic [7:0] bq[$], input int dq[$],
                              input int ctrl_cyc, input logic [31:0] ctrl_val);
        bit exp[$];
        int cnt_seq[$];
        int n;
        int total;
        int tx_err;
        int first_err;
        int irq_n;
        int irq_idx;
        int last_cnt;
        int start_rec;
        int cnt_err;
        n = bq.size();
        tx_err = 0;
        first_err = -1;
        irq_n = 0;
        irq_idx = -1;
        last_cnt = -1;
        cnt_err = 0;
        foreach (bq[i]) begin
            bit bits[$];
            bits.push_back(1'b0);
            for (int j = 0; j < 8; j++) bits.push_back(bq[i][j]);
            if (PAR_EN) bits.push_back(^bq[i]);
            bits.push_back(1'b1);
            foreach (bits[j]) repeat (dq[i]) exp.push_back(bits[j]);
        end
        total = exp.size();
        start_rec = (n > 1) ? n - 1 : 1;
        for (int cyc = 0; cyc < total + 8; cyc++) begin
            int idx;
            bit exp_tx;
            if (cyc < n) begin
                we = 1'b1; reg_sel = 1'b0; wdata = {24'h0, bq[cyc]};
            end else if (cyc == ctrl_cyc) begin
                we = 1'b1; reg_sel = 1'b1; wdata = ctrl_val;
            end else begin
                we = 1'b0; wdata = '0;
            end
            @(posedge clk);
            #1;
            idx = cyc - 2;
            exp_tx = (idx >= 0 && idx < total) ? exp[idx] : 1'b1;
            if (tx !== exp_tx) begin
                if (first_err < 0) first_err = idx;
                tx_err++;
            end
            if (irq === 1'b1) begin
                irq_n++;
                irq_idx = idx;
            end
            if (cyc >= start_rec && int'(rdata[11:4]) != last_cnt) begin
                last_cnt = int'(rdata[11:4]);
                cnt_seq.push_back(last_cnt);
            end
        end
        we = 1'b0;
        wdata = '0;
        if (cnt_seq.size() != n) cnt_err = 1;
        else foreach (cnt_seq[i]) if (cnt_seq[i] != n - 1 - i) cnt_err++;
        check($sformatf("%s_tx_wave(first_bad=%0d)", nm, first_err), tx_err, 0);
        check({nm, "_irq_pulses"}, irq_n, 1);
        check({nm, "_irq_pos"}, irq_idx, total);
        check({nm, "_count_seq"}, cnt_err, 0);
        check({nm, "_idle_busy"}, busy, 1'b0);
        check({nm, "_idle_empty"}, rdata[0], 1'b1);
    endtask

    initial begin
        logic [7:0] bq[$];
        int dq[$];
        int irq_seen;
        int tx_bad;

        vecs[0] = '{1'b1, 32'h0000_0001, {16'd2, ST_IDLE_LO}};
        vecs[1] = '{1'b1, 32'h0000_0000, {16'd2, ST_IDLE_LO}};
        vecs[2] = '{1'b1, 32'h0000_0003, {16'd3, ST_IDLE_LO}};
        vecs[3] = '{1'b1, 32'h8000_FFFF, {16'hFFFF, ST_IDLE_LO}};
        vecs[4] = '{1'b1, 32'h7FFF_0064, {16'd100, ST_IDLE_LO}};
        vecs[5] = '{1'b1, 32'h0000_0002, {16'd2, ST_IDLE_LO}};

        // Reset state
        step(3);
        rst = 1'b0;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_rdata", rdata, {16'd868, ST_IDLE_LO});

        // CTRL register vectors
        for (int i = 0; i < 6; i++) begin
            bus_write(vecs[i].sel, vecs[i].wd);
            check($sformatf("ctrl_vec%0d", i), rdata, vecs[i].exp_rd);
        end

        // Single 0x55 frame at divisor 4
        bus_write(1'b1, 32'd4);
        bq.delete(); dq.delete();
        bq.push_back(8'h55); dq.push_back(4);
        run_stream("b55", bq, dq, -1, '0);

        // Three back-to-back frames at divisor 2
        bus_write(1'b1, 32'd2);
        bq.delete(); dq.delete();
        bq.push_back(8'hA5); bq.push_back(8'h3C); bq.push_back(8'hFF);
        dq.push_back(2); dq.push_back(2); dq.push_back(2);
        run_stream("b3", bq, dq, -1, '0);

        // Divisor change mid-frame: first frame stays at 4, second uses 8
        bus_write(1'b1, 32'd4);
        bq.delete(); dq.delete();
        bq.push_back(8'hC3); bq.push_back(8'h5A);
        dq.push_back(4); dq.push_back(8);
        run_stream("divchg", bq, dq, 10, 32'd8);
        check("divchg_reg", rdata[31:16], 16'd8);

        // Parity-sensitive frame (8E1 when parity is built in)
        bus_write(1'b1, 32'd4);
        bq.delete(); dq.delete();
        bq.push_back(8'h07); dq.push_back(4);
        run_stream("b07", bq, dq, -1, '0);

        // FIFO fill, overflow, clear, and push while full coinciding with a pop
        bus_write(1'b1, 32'd1000);
        for (int i = 0; i < 17; i++) bus_write(1'b0, 32'(i));
        check("fill_count", rdata[11:4], 8'd16);
        check("fill_full", rdata[1], 1'b1);
        check("fill_ovf", rdata[3], 1'b0);
        bus_write(1'b0, 32'h0000_00EE);
        check("ovf_set", rdata[3], 1'b1);
        check("ovf_count", rdata[11:4], 8'd16);
        bus_write(1'b1, 32'h8000_03E8);
        check("ovf_clr", rdata[3], 1'b0);
        check("ovf_clr_div", rdata[31:16], 16'd1000);
        step(9982);
        check("pre_pop_count", rdata[11:4], 8'd16);
        bus_write(1'b0, 32'h0000_0077);
        check("pushpop_ovf", rdata[3], 1'b0);
        check("pushpop_count", rdata[11:4], 8'd16);
        check("pushpop_full", rdata[1], 1'b1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("flush_empty", rdata[0], 1'b1);

        // Reset while a data bit drives tx low
        bus_write(1'b1, 32'd4);
        bus_write(1'b0, 32'h0000_0000);
        bus_write(1'b0, 32'h0000_0000);
        step(6);
        check("mid_tx_low", tx, 1'b0);
        rst = 1'b1;
        step(1);
        check("midrst_tx", tx, 1'b1);
        check("midrst_empty", rdata[0], 1'b1);
        check("midrst_div", rdata[31:16], 16'd868);
        check("midrst_irq", irq, 1'b0);
        rst = 1'b0;
        irq_seen = 0;
        tx_bad = 0;
        for (int c = 0; c < 60; c++) begin
            step(1);
            if (irq !== 1'b0) irq_seen++;
            if (tx !== 1'b1) tx_bad++;
        end
        check("midrst_no_irq", irq_seen, 0);
        check("midrst_tx_idle", tx_bad, 0);

        // Random streams against the framing model
        for (int r = 0; r < 6; r++) begin
            int nb;
            int dv;
            nb = $urandom_range(1, 6);
            dv = $urandom_range(2, 5);
            bus_write(1'b1, 32'(dv));
            bq.delete(); dq.delete();
            for (int i = 0; i < nb; i++) begin
                bq.push_back(8'($urandom_range(0, 255)));
                dq.push_back(dv);
            end
            run_stream($sformatf("rnd%0d", r), bq, dq, -1, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter on the MIO bus, alongside the GPIO and counter peripherals.
- The CPU writes bytes through the bus write strobe and write data (Peripheral_in path). They are buffered in a FIFO and serialised 8N1 on `tx`.
- A status word is returned to the bus read mux for CPU polling.
- `irq` indicates that the FIFO has drained.

Parameters:
- FIFO_DEPTH, 16, number of byte entries; must be a power of 2, minimum 2.
- DIV_RESET, 868, reset baud divisor in clk cycles per bit (100 MHz / 115200).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- we  input  1  bus write strobe for this peripheral, one cycle per access.
- reg_sel  input  1  0 = DATA register, 1 = CTRL register.
- wdata  input  32  bus write data.
- rdata  output  32  status word, combinational from registered state.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is being shifted or the FIFO is non-empty.
- irq  output  1  one-cycle pulse when the last queued frame's stop bit completes.

Behaviour:
- Reset values:
  - tx=1, busy=0, irq=0.
  - FIFO empty; overflow flag=0.
  - divisor=DIV_RESET; FSM in IDLE.
  - rdata reflects these values.
- DATA write (we=1, reg_sel=0):
  - If the FIFO is not full, push wdata[7:0].
  - If the FIFO is full, drop the byte and set the sticky overflow flag. FIFO contents are unchanged.
- CTRL write (we=1, reg_sel=1):
  - divisor_reg <= max(wdata[15:0], 2).
  - If wdata[31]=1, clear overflow.
  - A new divisor applies from the next frame start only. The current frame keeps its latched divisor.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into shift_reg, latch divisor, load baud_cnt=divisor-1, go to START. tx=0 from the next cycle.
  - Every state holds for divisor cycles: baud_cnt decrements, and on reaching 0 the state advances and baud_cnt reloads.
  - DATA: 8 bits, LSB first. bit_idx runs 0..7, and tx=shift_reg[bit_idx].
  - STOP: tx=1 for one bit period.
    - At the end of STOP, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE and pulse irq for 1 cycle.
- Latency: a DATA write captured at edge k into an empty FIFO while IDLE is popped at edge k+1. tx=0 after edge k+2.
- Frame length is exactly 10*divisor cycles; tx is glitch-free because it is driven from a register.
- Push and pop in the same cycle:
  - Both take effect and the count is unchanged.
  - If the FIFO is full, the pop frees a slot, so the push is accepted with no overflow.
- Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.
- rdata layout:
  - bit0 empty.
  - bit1 full.
  - bit2 busy.
  - bit3 overflow.
  - [11:4] count, zero-extended.
  - [15:12] 0.
  - [31:16] divisor_reg.
- busy = (state!=IDLE) | !empty.
- Reset mid-frame: tx returns to 1 on the next edge, the FIFO is flushed, and divisor returns to DIV_RESET.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. tx = ^shift_reg (even parity).
  - Frame length is 11*divisor cycles.
  - rdata[12]=1 reports that parity is present.
- Undefined: no PARITY state, frames are 8N1, and rdata[12]=0.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE/START/DATA/STOP/PARITY);
  - register select constants REG_DATA=0 and REG_CTRL=1;
  - status bit indices ST_EMPTY, ST_FULL, ST_BUSY, ST_OVF, ST_CNT_LSB, ST_PAR, ST_DIV_LSB;
  - DIV_MIN=2.
- One sub-module, sync_fifo:
  - parameterised width/depth;
  - push/pop/full/empty/count interface;
  - same clk/rst convention.

Test Plan:
- Reset, then write DATA 0x55 with divisor=4. tx samples every 4 cycles: 0,1,0,1,0,1,0,1,0,1. irq pulses once 40 cycles after the frame start; busy=0 afterward.
- Write 3 bytes back-to-back (0xA5, 0x3C, 0xFF) with divisor=2. Three contiguous frames of 20 cycles each with no idle gap. The count read sequence is 2,1,0 as each byte is popped.
- Write 17 bytes while divisor=1000. The first byte is popped, 16 are buffered, and the 17th is accepted (count=16, full=1). An 18th write sets overflow=1 with count unchanged. A CTRL write with wdata[31]=1 clears overflow.
- CTRL write of 0x0000_0001 → rdata[31:16]=2. A CTRL write of 8 issued mid-frame leaves the current frame at the old divisor; the next frame uses 8 cycles per bit.
- Assert rst during a DATA bit that is driving tx=0. After the next edge: tx=1, empty=1, rdata[31:16]=868, and no irq.
- With UART_TX_PARITY_EN defined, write 0x07. The frame is start, 1,1,1,0,0,0,0,0, parity=1, stop, totalling 11 bit periods.
